pixel_layer_arbiter: RTL and testbench

Per-pixel arbiter between the sprite/layer renderers (ship, aliens, shields, bullets) and the VGA color output. Each pixel strobe, it picks the highest-priority opaque layer color and registers it with its coordinates. It forces black outside the visible 640x480 area. It also accumulates pairwise layer overlaps over a frame and hands a collision report to game logic with a valid/ack handshake.

---
 rtl/pixel_layer_arbiter.sv | 125 ++++++++++++
 tb/tb_pixel_layer_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_layer_arbiter.sv
`default_nettype none
// ============================================================================
// pixel_layer_arbiter: per-pixel layer priority mux with frame collision report
// Revision: 1.0
// ============================================================================
module pixel_layer_arbiter #(
  parameter int         NUM_LAYERS    = 4,
  parameter int         SCREEN_WIDTH  = 640,
  parameter int         SCREEN_HEIGHT = 480,
  parameter logic [2:0] NONE          = 3'd7,
  parameter logic [2:0] BACKGROUND    = 3'd0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pix_en,
  input  logic [9:0]                       hPos,
  input  logic [9:0]                       vPos,
  input  logic [3*NUM_LAYERS-1:0]          layer_color,
  input  logic [NUM_LAYERS-1:0]            layer_en,
  output logic [2:0]                       color,
  output logic [9:0]                       hPos_out,
  output logic [9:0]                       vPos_out,
  output logic                             coll_valid,
  output logic [NUM_LAYERS*NUM_LAYERS-1:0] coll_mask,
  output logic                             coll_overrun,
  input  logic                             coll_ack
);

  localparam int         c_MASK_W = NUM_LAYERS * NUM_LAYERS;
  localparam logic [9:0] c_WIDTH  = 10'(SCREEN_WIDTH);
  localparam logic [9:0] c_HEIGHT = 10'(SCREEN_HEIGHT);

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    ACCUM    = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [c_MASK_W-1:0]   r_acc;
  logic [c_MASK_W-1:0]   w_pairs;
  logic [NUM_LAYERS-1:0] w_opaque;
  logic [2:0]            w_pixColor;
  logic                  w_visible;
  logic                  w_sof;
  logic                  w_eof;
  logic                  w_accumEn;

  assign w_visible = (hPos < c_WIDTH) && (vPos < c_HEIGHT);
  assign w_sof     = pix_en && (hPos == 10'd0) && (vPos == 10'd0);
  assign w_eof     = pix_en && (hPos == 10'd0) && (vPos == c_HEIGHT) && (r_state == ACCUM);
  // The SOF pixel itself belongs to the frame, so it is accumulated while still in WAIT_SOF.
  assign w_accumEn = pix_en && w_visible && ((r_state == ACCUM) || w_sof);

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_opaque
    assign w_opaque[gi] = layer_en[gi] && (layer_color[3*gi +: 3] != NONE);
  end

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_row
    for (genvar gj = 0; gj < NUM_LAYERS; gj++) begin : g_col
      if (gi < gj) begin : g_pair
        assign w_pairs[gi*NUM_LAYERS+gj] = w_opaque[gi] & w_opaque[gj];
      end else begin : g_zero
        assign w_pairs[gi*NUM_LAYERS+gj] = 1'b0;
      end
    end
  end

  always_comb begin
    w_pixColor = BACKGROUND;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (w_opaque[i]) w_pixColor = layer_color[3*i +: 3];
    end
  end

  always_comb begin
    w_nextState = r_state;
    if ((r_state == WAIT_SOF) && w_sof) w_nextState = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_SOF;
    else        r_state <= w_nextState;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color    <= 3'd0;
      hPos_out <= 10'd0;
      vPos_out <= 10'd0;
    end else if (pix_en) begin
      color    <= w_visible ? w_pixColor : 3'd0;
      hPos_out <= hPos;
      vPos_out <= vPos;
    end
  end

  // The EOF pixel is never visible, so clearing acc on EOF cannot drop a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      coll_valid   <= 1'b0;
      coll_mask    <= '0;
      coll_overrun <= 1'b0;
    end else if (w_eof) begin
      r_acc <= '0;
      if (!coll_valid || coll_ack) begin
        coll_mask    <= r_acc;
        coll_valid   <= 1'b1;
        coll_overrun <= 1'b0;
      end else begin
        coll_mask    <= coll_mask | r_acc;
        coll_overrun <= 1'b1;
      end
    end else begin
      if (w_accumEn) r_acc <= r_acc | w_pairs;
      if (coll_ack && coll_valid) begin
        coll_valid   <= 1'b0;
        coll_overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_layer_arbiter.sv
`default_nettype none
// ============================================================================
// tb_pixel_layer_arbiter: directed stimulus, per-cycle model compare plus literal pins
// Revision: 1.0
// ============================================================================
module tb_pixel_layer_arbiter;

  localparam logic [2:0] T = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic        coll_ack = 1'b0;
  logic [9:0]  hPos = 10'd0;
  logic [9:0]  vPos = 10'd0;
  logic [11:0] layer_color = {4{T}};
  logic [3:0]  layer_en = 4'h0;
  logic [2:0]  color;
  logic [9:0]  hPos_out;
  logic [9:0]  vPos_out;
  logic        coll_valid;
  logic [15:0] coll_mask;
  logic        coll_overrun;

  int errors = 0;
  int checks = 0;
  bit cmpOn  = 1'b0;

  pixel_layer_arbiter dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hPos(hPos), .vPos(vPos),
    .layer_color(layer_color), .layer_en(layer_en), .color(color),
    .hPos_out(hPos_out), .vPos_out(vPos_out), .coll_valid(coll_valid),
    .coll_mask(coll_mask), .coll_overrun(coll_overrun), .coll_ack(coll_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] lc(input logic [2:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [2:0] arb(input logic [9:0] h, v, input logic [11:0] c, input logic [3:0] e);
    if (h >= 640 || v >= 480) return 3'd0;
    for (int i = 0; i < 4; i++)
      if (e[i] && c[3*i +: 3] != T) return c[3*i +: 3];
    return 3'd0;
  endfunction

  function automatic logic [15:0] pairs(input logic [11:0] c, input logic [3:0] e);
    logic [15:0] m;
    m = 16'h0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (e[i] && c[3*i +: 3] != T && e[j] && c[3*j +: 3] != T) m[i*4+j] = 1'b1;
    return m;
  endfunction

  // Reference model
  logic [2:0]  mColor;
  logic [9:0]  mH, mV;
  logic        mValid, mOverrun, mInFrame;
  logic [15:0] mMask, mAcc;
  logic        mVis, mSof, mEof;

  assign mVis = (hPos < 10'd640) && (vPos < 10'd480);
  assign mSof = pix_en && hPos == 10'd0 && vPos == 10'd0;
  assign mEof = pix_en && hPos == 10'd0 && vPos == 10'd480 && mInFrame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mColor <= 3'd0; mH <= 10'd0; mV <= 10'd0;
      mValid <= 1'b0; mOverrun <= 1'b0; mInFrame <= 1'b0;
      mMask <= 16'h0; mAcc <= 16'h0;
    end else begin
      if (pix_en) begin
        mColor <= arb(hPos, vPos, layer_color, layer_en);
        mH     <= hPos;
        mV     <= vPos;
      end
      if (mSof) mInFrame <= 1'b1;
      if (mEof) begin
        mAcc <= 16'h0;
        if (!mValid || coll_ack) begin
          mMask <= mAcc; mValid <= 1'b1; mOverrun <= 1'b0;
        end else begin
          mMask <= mMask | mAcc; mOverrun <= 1'b1;
        end
      end else begin
        if (pix_en && mVis && (mInFrame || mSof)) mAcc <= mAcc | pairs(layer_color, layer_en);
        if (coll_ack && mValid) begin
          mValid <= 1'b0; mOverrun <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmpOn && rst_n) begin
      check("color", 32'(color), 32'(mColor));
      check("hPos_out", 32'(hPos_out), 32'(mH));
      check("vPos_out", 32'(vPos_out), 32'(mV));
      check("coll_valid", 32'(coll_valid), 32'(mValid));
      check("coll_mask", 32'(coll_mask), 32'(mMask));
      check("coll_overrun", 32'(coll_overrun), 32'(mOverrun));
    end
  end

  task automatic drive(input logic pe, input logic [9:0] h, v, input logic [11:0] c,
                       input logic [3:0] e, input logic ack);
    @(negedge clk);
    pix_en = pe; hPos = h; vPos = v; layer_color = c; layer_en = e; coll_ack = ack;
    @(posedge clk);
    #1;
    pix_en = 1'b0; coll_ack = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_color"}, 32'(color), 32'd0);
    check({tag, "_hpos"}, 32'(hPos_out), 32'd0);
    check({tag, "_vpos"}, 32'(vPos_out), 32'd0);
    check({tag, "_valid"}, 32'(coll_valid), 32'd0);
    check({tag, "_mask"}, 32'(coll_mask), 32'd0);
    check({tag, "_overrun"}, 32'(coll_overrun), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cmpOn = 1'b1;

    // Priority
    drive(1, 100, 100, lc(T, 3'b010, 3'b100, 3'b001), 4'hF, 0);
    check("prio_all", 32'(color), 32'h2);
    check("prio_hpos", 32'(hPos_out), 32'd100);
    drive(1, 100, 100, lc(T, 3'b010, 3'b100, 3'b001), 4'b1101, 0);
    check("prio_l1_off", 32'(color), 32'h4);
    drive(1, 100, 100, lc(T, T, T, T), 4'hF, 0);
    check("prio_bg", 32'(color), 32'h0);

    // Blanking edges
    drive(1, 639, 479, lc(3'b101, T, T, T), 4'hF, 0);
    check("blank_639_479", 32'(color), 32'h5);
    drive(1, 640, 0, lc(3'b101, T, T, T), 4'hF, 0);
    check("blank_640_0", 32'(color), 32'h0);
    drive(1, 0, 480, lc(3'b101, T, T, T), 4'hF, 0);
    check("blank_0_480", 32'(color), 32'h0);
    check("no_report_before_sof", 32'(coll_valid), 32'd0);

    // Single collision frame
    drive(1, 0, 0, lc(T, T, T, T), 4'hF, 0);
    drive(1, 10, 10, lc(3'd3, T, 3'd6, T), 4'hF, 0);
    drive(1, 640, 10, lc(T, 3'd1, T, 3'd2), 4'hF, 0);
    drive(0, 0, 0, lc(T, T, T, T), 4'h0, 0);
    drive(1, 0, 480, lc(T, T, T, T), 4'hF, 0);
    check("coll_valid", 32'(coll_valid), 32'd1);
    check("coll_mask", 32'(coll_mask), 32'h0004);
    drive(0, 0, 0, lc(T, T, T, T), 4'h0, 1);
    check("ack_valid", 32'(coll_valid), 32'd0);
    check("ack_mask_hold", 32'(coll_mask), 32'h0004);

    // Overrun across two EOFs
    drive(1, 20, 20, lc(3'd1, T, 3'd2, T), 4'hF, 0);
    drive(1, 0, 480, lc(T, T, T, T), 4'hF, 0);
    drive(1, 30, 30, lc(T, 3'd1, T, 3'd2), 4'hF, 0);
    drive(1, 0, 480, lc(T, T, T, T), 4'hF, 0);
    check("ovr_mask", 32'(coll_mask), 32'h0084);
    check("ovr_flag", 32'(coll_overrun), 32'd1);
    check("ovr_valid", 32'(coll_valid), 32'd1);
    drive(0, 0, 0, lc(T, T, T, T), 4'h0, 1);
    check("ovr_ack_valid", 32'(coll_valid), 32'd0);
    check("ovr_ack_flag", 32'(coll_overrun), 32'd0);

    // EOF and ack together
    drive(1, 40, 40, lc(3'd1, 3'd2, T, T), 4'hF, 0);
    drive(1, 0, 480, lc(T, T, T, T), 4'hF, 0);
    check("sim_first_mask", 32'(coll_mask), 32'h0002);
    drive(1, 50, 50, lc(T, T, 3'd3, 3'd4), 4'hF, 0);
    drive(1, 0, 480, lc(T, T, T, T), 4'hF, 1);
    check("sim_valid", 32'(coll_valid), 32'd1);
    check("sim_mask", 32'(coll_mask), 32'h0800);
    check("sim_overrun", 32'(coll_overrun), 32'd0);

    // Reset mid-frame with a pending report
    drive(1, 60, 60, lc(3'd1, T, T, 3'd2), 4'hF, 0);
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 5, 5, lc(3'd1, 3'd2, T, T), 4'hF, 0);
    drive(1, 0, 480, lc(T, T, T, T), 4'hF, 0);
    check("post_reset_no_report", 32'(coll_valid), 32'd0);
    drive(1, 0, 0, lc(T, T, 3'd3, 3'd4), 4'hF, 0);
    drive(1, 0, 480, lc(T, T, T, T), 4'hF, 0);
    check("post_reset_valid", 32'(coll_valid), 32'd1);
    check("post_reset_mask", 32'(coll_mask), 32'h0800);

    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
